// File: rtl/dmem_latency_slave_pkg.sv
// Shared types for the latency-controlled data memory slave.
// The optional protocol checker is enabled by defining DMEM_PROTO_CHECK_EN.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/dmem_latency_slave_if.sv
// CPU data-bus request/response plus the write-monitor port feeding the result checker.
interface dmem_latency_slave_if #(
    parameter int ADDR_W = 30
);
    import dmem_pkg::*;

    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic [WORD_W-1:0]   mem_rdata;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mon_addr;
    logic [WORD_W-1:0]   mon_data;
    logic                mon_wen;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, mon_addr, mon_data, mon_wen
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, mon_addr, mon_data, mon_wen
    );

endinterface

// File: rtl/dmem_latency_slave_array.sv
// DEPTH x 32 word store: synchronous write, combinational read, out-of-range
// accesses ignored on write and read as zero; contents cleared by reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [WORD_W-1:0]   wdata_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [WORD_W-1:0]   rdata_o
);
    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  wsel;

    // Full-width address compare, so an out-of-range write selects no word.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
        assign wsel[gi] = we_i && (waddr_i == ADDR_W'(gi));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wsel[i]) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        if ({1'b0, raddr_i} < DEPTH_L) begin
            rdata_o = mem_q[raddr_i[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/dmem_latency_slave.sv
// Fixed-latency word memory slave with one-cycle ready pulse and write monitor.
// Optional sticky protocol-error output when DMEM_PROTO_CHECK_EN is defined.
module dmem_latency_slave
    import dmem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_latency_slave_if.slave   bus
`ifdef DMEM_PROTO_CHECK_EN
    ,
    output logic                  proto_err
`endif
);
    localparam int CNT_W = 4;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic [ADDR_W-1:0]   mon_addr_q, mon_addr_d;
    logic [WORD_W-1:0]   mon_data_q, mon_data_d;
    logic                mon_wen_q, mon_wen_d;
    logic [WORD_W-1:0]   arr_rdata;
    logic                arr_we;

    // Commit happens at the end of the RESP cycle, from the captured request.
    assign arr_we = (state_q == RESP) && (op_q == OP_WR);

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (addr_d),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mon_addr_d = mon_addr_q;
        mon_data_d = mon_data_q;
        ready_d    = 1'b0;
        mon_wen_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    op_d    = bus.mem_write ? OP_WR : OP_RD;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered: load them on the edge that enters RESP so
        // they are valid for exactly the RESP cycle.
        if ((state_d == RESP) && (state_q != RESP)) begin
            ready_d = 1'b1;
            if (op_d == OP_WR) begin
                mon_wen_d  = 1'b1;
                mon_addr_d = addr_d;
                mon_data_d = wdata_d;
            end else begin
                rdata_d = arr_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_RD;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            mon_addr_q <= '0;
            mon_data_q <= '0;
            mon_wen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            mon_addr_q <= mon_addr_d;
            mon_data_q <= mon_data_d;
            mon_wen_q  <= mon_wen_d;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mon_addr  = mon_addr_q;
    assign bus.mon_data  = mon_data_q;
    assign bus.mon_wen   = mon_wen_q;

`ifdef DMEM_PROTO_CHECK_EN
    logic [1:0] req_q, req_d;
    logic       proto_err_q;
    logic       proto_set;

    assign req_d = (state_q == IDLE) ? {bus.mem_read, bus.mem_write} : req_q;

    always_comb begin
        proto_set = 1'b0;
        if ((state_q == IDLE) && bus.mem_read && bus.mem_write) begin
            proto_set = 1'b1;
        end
        // A dropped request also shows up as a change in the read/write pair.
        if ((state_q == WAIT) &&
            (({bus.mem_read, bus.mem_write} != req_q) ||
             (bus.mem_addr != addr_q) || (bus.mem_wdata != wdata_q))) begin
            proto_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q       <= 2'b00;
            proto_err_q <= 1'b0;
        end else begin
            req_q       <= req_d;
            proto_err_q <= proto_err_q | proto_set;
        end
    end

    assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_dmem_latency_slave.sv
// Scoreboard bench: two slaves (LATENCY=4/DEPTH=256 and LATENCY=1/DEPTH=128)
// driven with directed vectors; a negedge monitor checks every ready pulse.
module tb_dmem_latency_slave;

    typedef struct {
        logic        is_wr;
        logic [29:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          compared;
    int          mismatched;
    int          lat [2];
    exp_t        qa [$];
    exp_t        qc [$];

    logic [1:0]  rd, wr, rdy, wen, perr;
    logic [29:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic [29:0] madr [2];
    logic [31:0] mdat [2];

    dmem_latency_slave_if #(.ADDR_W(30)) if_a ();
    dmem_latency_slave_if #(.ADDR_W(30)) if_c ();

    assign if_a.mem_read  = rd[0];
    assign if_a.mem_write = wr[0];
    assign if_a.mem_addr  = addr[0];
    assign if_a.mem_wdata = wdat[0];
    assign if_c.mem_read  = rd[1];
    assign if_c.mem_write = wr[1];
    assign if_c.mem_addr  = addr[1];
    assign if_c.mem_wdata = wdat[1];
    assign rdy  = {if_c.mem_ready, if_a.mem_ready};
    assign wen  = {if_c.mon_wen, if_a.mon_wen};
    assign rdat[0] = if_a.mem_rdata;
    assign rdat[1] = if_c.mem_rdata;
    assign madr[0] = if_a.mon_addr;
    assign madr[1] = if_c.mon_addr;
    assign mdat[0] = if_a.mon_data;
    assign mdat[1] = if_c.mon_data;

    dmem_latency_slave #(.LATENCY(4), .DEPTH(256), .ADDR_W(30)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (if_a)
`ifdef DMEM_PROTO_CHECK_EN
        ,
        .proto_err (perr[0])
`endif
    );

    dmem_latency_slave #(.LATENCY(1), .DEPTH(128), .ADDR_W(30)) dut_c (
        .clk       (clk),
        .rst       (rst),
        .bus       (if_c)
`ifdef DMEM_PROTO_CHECK_EN
        ,
        .proto_err (perr[1])
`endif
    );

`ifndef DMEM_PROTO_CHECK_EN
    assign perr = 2'b00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request, queue its expected response, hold until ready.
    task automatic req(input int d, input logic r, input logic w, input logic [29:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
        exp_t e;
        bit   seen;
        @(negedge clk);
        rd[d] = r; wr[d] = w; addr[d] = a; wdat[d] = wd;
        e.is_wr = w; e.addr = a; e.data = wd; e.rdata = exp_rd; e.cyc = cyc + lat[d];
        if (d == 0) qa.push_back(e); else qc.push_back(e);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy[d]) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            mismatched++;
            $display("FAIL timeout_d%0d actual=no_ready required=ready", d);
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                if (rdy[d]) begin
                    if ((d == 0 && qa.size() == 0) || (d == 1 && qc.size() == 0)) begin
                        mismatched++;
                        $display("FAIL d%0d_spurious_ready actual=1 required=0", d);
                    end else begin
                        exp_t e;
                        if (d == 0) e = qa.pop_front(); else e = qc.pop_front();
                        $display("txn dut%0d %s addr=%0d wdata=%h rdata=%h cyc=%0d",
                                 d, e.is_wr ? "WR" : "RD", e.addr, e.data, rdat[d], cyc);
                        chk($sformatf("d%0d_ready_cycle", d), 32'(cyc), 32'(e.cyc));
                        chk($sformatf("d%0d_mon_wen", d), 32'(wen[d]), 32'(e.is_wr));
                        chk($sformatf("d%0d_mem_rdata", d), rdat[d], e.rdata);
                        if (e.is_wr) begin
                            chk($sformatf("d%0d_mon_addr", d), 32'(madr[d]), 32'(e.addr));
                            chk($sformatf("d%0d_mon_data", d), mdat[d], e.data);
                        end
                    end
                end else if (wen[d]) begin
                    mismatched++;
                    $display("FAIL d%0d_wen_without_ready actual=1 required=0", d);
                end
            end
        end
    end

    initial begin
        lat[0] = 4; lat[1] = 1;
        compared = 0; mismatched = 0; cyc = 0;
        rd = 2'b00; wr = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdat[d] = '0;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_ready", d), 32'(rdy[d]), 32'd0);
            chk($sformatf("d%0d_rst_wen", d), 32'(wen[d]), 32'd0);
            chk($sformatf("d%0d_rst_rdata", d), rdat[d], 32'd0);
            chk($sformatf("d%0d_rst_mon_addr", d), 32'(madr[d]), 32'd0);
            chk($sformatf("d%0d_rst_mon_data", d), mdat[d], 32'd0);
        end
        rst = 1'b1;

        // LATENCY=1, DEPTH=128: basic access, read+write collision, out-of-range.
        req(1, 0, 1, 30'd5,   32'h1111_2222, 32'h0);
        req(1, 1, 0, 30'd5,   32'h0,         32'h1111_2222);
        req(1, 1, 1, 30'd7,   32'h0000_0005, 32'h1111_2222);
        req(1, 1, 0, 30'd7,   32'h0,         32'h0000_0005);
        req(1, 0, 1, 30'd255, 32'hDEAD_BEEF, 32'h0000_0005);
        req(1, 1, 0, 30'd255, 32'h0,         32'h0);
        req(1, 1, 0, 30'd127, 32'h0,         32'h0);
        req(1, 1, 0, 30'd5,   32'h0,         32'h1111_2222);
        req(1, 1, 0, 30'd7,   32'h0,         32'h0000_0005);

        // LATENCY=4, DEPTH=256: write-then-read, then back-to-back writes.
        req(0, 0, 1, 30'd128, 32'h7856_3412, 32'h0);
        req(0, 1, 0, 30'd128, 32'h0,         32'h7856_3412);
        for (int i = 0; i < 8; i++) begin
            req(0, 0, 1, 30'(128 + i), 32'hA000_0000 + 32'(i), 32'h7856_3412);
        end
        req(0, 1, 0, 30'd131, 32'h0, 32'hA000_0003);
        req(0, 1, 0, 30'd135, 32'h0, 32'hA000_0007);

        // Reset in WAIT of a write to 3: aborted, outputs cleared, nothing committed.
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 30'd3; wdat[0] = 32'hCAFE_0003;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy[0]), 32'd0);
        chk("abort_wen", 32'(wen[0]), 32'd0);
        chk("abort_rdata", rdat[0], 32'd0);
        chk("abort_mon_addr", 32'(madr[0]), 32'd0);
        chk("abort_mon_data", mdat[0], 32'd0);
        wr[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        req(0, 1, 0, 30'd3,   32'h0, 32'h0);
        req(0, 1, 0, 30'd128, 32'h0, 32'h0);

`ifdef DMEM_PROTO_CHECK_EN
        chk("proto_clean", 32'(perr[0]), 32'd0);
        begin
            exp_t e;
            bit   seen;
            @(negedge clk);
            rd[0] = 1'b1; addr[0] = 30'd10;
            e.is_wr = 1'b0; e.addr = 30'd10; e.data = 32'h0; e.rdata = 32'h0; e.cyc = cyc + 4;
            qa.push_back(e);
            @(negedge clk);
            addr[0] = 30'd11;
            seen = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (rdy[0]) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) begin
                mismatched++;
                $display("FAIL proto_timeout actual=no_ready required=ready");
            end
            rd[0] = 1'b0;
        end
        chk("proto_set", 32'(perr[0]), 32'd1);
        repeat (3) @(negedge clk);
        chk("proto_sticky", 32'(perr[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("proto_rst", 32'(perr[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
`endif

        repeat (4) @(negedge clk);
        chk("queue_a_empty", 32'(qa.size()), 32'd0);
        chk("queue_c_empty", 32'(qc.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
